cva6_irq_conditioner: RTL and testbench

- Parametrised interrupt front-end between block-design interrupt sources and the CVA6 core interrupt inputs.
- Generalises the fixed rising-edge interrupt pins to NUM_IRQ channels, with:
  - per-channel edge or level mode
  - input synchronisation
  - pending and in-service tracking
  - per-target enables
  - a claim/complete handshake
- Drives one interrupt line per privilege target (M, S, ...) into the core wrapper.

---
 rtl/cva6_irq_conditioner.sv | 147 ++++++++++++++
 tb/tb_cva6_irq_conditioner.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_irq_conditioner.sv
// Interrupt front-end for the CVA6 core interrupt inputs.
//
// Each of NUM_IRQ asynchronous sources goes through a synchroniser. It is then
// tracked as pending (rising-edge or level mode, chosen per channel by
// EDGE_MASK) and as in-service. The channel is routed to NUM_TARGETS
// privilege-level request lines through per-target enables. Software takes
// the lowest eligible channel with a claim strobe and releases it with a
// complete strobe.
//
// Ports:
//   aclk, areset       clock, synchronous active-high reset
//   irq_src_i          asynchronous interrupt sources, one per channel
//   irq_en_i           bit [t*NUM_IRQ+i] routes channel i to target t (quasi-static)
//   irqs_o             registered interrupt request per target
//   claim_i            one-cycle claim strobe for target claim_target_i
//   claim_ack_o        pulses one cycle after every claim_i
//   claim_hit_o        with claim_ack_o: a channel was claimed
//   claim_id_o         claimed channel ID (0 on a miss)
//   complete_i         one-cycle completion strobe for channel complete_id_i
module cva6_irq_conditioner #(
    parameter int unsigned        NUM_IRQ     = 8,
    parameter int unsigned        NUM_TARGETS = 2,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = {NUM_IRQ{1'b1}},
    parameter int unsigned        IDW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                                                     aclk,
    input  logic                                                     areset,
    input  logic [NUM_IRQ-1:0]                                       irq_src_i,
    input  logic [NUM_TARGETS*NUM_IRQ-1:0]                           irq_en_i,
    output logic [NUM_TARGETS-1:0]                                   irqs_o,
    input  logic                                                     claim_i,
    input  logic [((NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1)-1:0] claim_target_i,
    output logic                                                     claim_ack_o,
    output logic                                                     claim_hit_o,
    output logic [IDW-1:0]                                           claim_id_o,
    input  logic                                                     complete_i,
    input  logic [IDW-1:0]                                           complete_id_i
);

    // Synchroniser chain; the last stage is the synchronised source s.
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
    logic [NUM_IRQ-1:0]                  s, s_d_q, s_d_d, rise;

    logic [NUM_IRQ-1:0]                  pending_q, pending_d;
    logic [NUM_IRQ-1:0]                  in_service_q, in_service_d;
    logic [NUM_TARGETS-1:0]              irqs_q, irqs_d;
    logic                                claim_ack_q, claim_ack_d;
    logic                                claim_hit_q, claim_hit_d;
    logic [IDW-1:0]                      claim_id_q, claim_id_d;

    logic [NUM_TARGETS-1:0][NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0]                  claim_row;
    logic [NUM_IRQ-1:0]                  claimed;   // one-hot channel taken this edge
    logic [NUM_IRQ-1:0]                  completed; // one-hot channel released this edge

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_src_i};
        s      = sync_q[SYNC_STAGES-1];
        s_d_d  = s;
        rise   = s & ~s_d_q;
    end

    // Eligibility per target and the registered request lines.
    always_comb begin
        elig   = '0;
        irqs_d = '0;
        for (int unsigned t = 0; t < NUM_TARGETS; t++) begin
            elig[t]   = pending_q & ~in_service_q & irq_en_i[t*NUM_IRQ +: NUM_IRQ];
            irqs_d[t] = |elig[t];
        end
    end

    // Claim: lowest-index eligible channel of the addressed target. A target
    // index beyond NUM_TARGETS matches no row and therefore misses.
    always_comb begin
        claim_row = '0;
        for (int unsigned t = 0; t < NUM_TARGETS; t++) begin
            if (32'(claim_target_i) == t) begin
                claim_row = elig[t];
            end
        end
        claimed    = '0;
        claim_id_d = '0;
        if (claim_i) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                if (claim_row[i] && (claimed == '0)) begin
                    claimed[i] = 1'b1;
                    claim_id_d = IDW'(i);
                end
            end
        end
        claim_hit_d = |claimed;
        claim_ack_d = claim_i;
    end

    // Completion only acts on a channel that is actually in service; IDs at or
    // beyond NUM_IRQ never match and are dropped.
    always_comb begin
        completed = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            completed[i] = complete_i && (32'(complete_id_i) == i) && in_service_q[i];
        end
    end

    // Edge mode: a rise wins over a coincident claim so the new event is kept
    // (one deep). Level mode simply follows the synchronised source.
    always_comb begin
        pending_d = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                pending_d[i] = rise[i] | (pending_q[i] & ~claimed[i]);
            end else begin
                pending_d[i] = s[i];
            end
        end
        in_service_d = (in_service_q & ~completed) | claimed;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            sync_q       <= '0;
            s_d_q        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            irqs_q       <= '0;
            claim_ack_q  <= 1'b0;
            claim_hit_q  <= 1'b0;
            claim_id_q   <= '0;
        end else begin
            sync_q       <= sync_d;
            s_d_q        <= s_d_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            irqs_q       <= irqs_d;
            claim_ack_q  <= claim_ack_d;
            claim_hit_q  <= claim_hit_d;
            claim_id_q   <= claim_id_d;
        end
    end

    assign irqs_o      = irqs_q;
    assign claim_ack_o = claim_ack_q;
    assign claim_hit_o = claim_hit_q;
    assign claim_id_o  = claim_id_q;

endmodule

// File: tb/tb_cva6_irq_conditioner.sv
// Self-checking bench for cva6_irq_conditioner.
// A reference model keeps the sampled source history and derives the
// synchronised value and rising edges from it by indexing back SYNC_STAGES
// edges. Pending, in-service and claim results are then updated from the
// rules, once per clock edge. All DUT outputs are compared with the model
// after every edge. Directed scenarios add literal expectations. A long
// randomised phase follows.
`timescale 1ns/1ps
module tb_cva6_irq_conditioner;

    localparam int unsigned N    = 6;
    localparam int unsigned NT   = 3;
    localparam int unsigned S    = 2;
    localparam int unsigned IDW  = 3;
    localparam int unsigned TW   = 2;
    localparam logic [N-1:0] EMASK = 6'b111101; // ch1 is level, the rest edge
    localparam int MAXC = 8192;

    logic              aclk;
    logic              areset;
    logic [N-1:0]      irq_src_i;
    logic [NT*N-1:0]   irq_en_i;
    logic [NT-1:0]     irqs_o;
    logic              claim_i;
    logic [TW-1:0]     claim_target_i;
    logic              claim_ack_o;
    logic              claim_hit_o;
    logic [IDW-1:0]    claim_id_o;
    logic              complete_i;
    logic [IDW-1:0]    complete_id_i;

    cva6_irq_conditioner #(
        .NUM_IRQ     (N),
        .NUM_TARGETS (NT),
        .SYNC_STAGES (S),
        .EDGE_MASK   (EMASK)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .irq_src_i      (irq_src_i),
        .irq_en_i       (irq_en_i),
        .irqs_o         (irqs_o),
        .claim_i        (claim_i),
        .claim_target_i (claim_target_i),
        .claim_ack_o    (claim_ack_o),
        .claim_hit_o    (claim_hit_o),
        .claim_id_o     (claim_id_o),
        .complete_i     (complete_i),
        .complete_id_i  (complete_id_i)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state.
    int           cyc      = 0;
    int           last_rst = -1;
    logic [N-1:0] raw [MAXC];
    logic [N-1:0] m_pend   = '0;
    logic [N-1:0] m_insvc  = '0;
    logic [NT-1:0] m_irqs  = '0;
    logic         m_ack    = 1'b0;
    logic         m_hit    = 1'b0;
    logic [IDW-1:0] m_id   = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Source value as seen through the synchroniser history; anything sampled
    // on or before the last reset edge has been flushed.
    function automatic logic [N-1:0] samp(input int m);
        if (m < 0 || m <= last_rst) return '0;
        return raw[m];
    endfunction

    // One clock edge: advance the model, compare every output, drop strobes.
    task automatic cycle();
        logic [N-1:0]   s, sd, rise, row, pend_n, svc_n;
        logic [NT-1:0]  irqs_n;
        logic           hit_n;
        logic [IDW-1:0] id_n;
        int             tgt, cid;
        @(posedge aclk);
        raw[cyc] = irq_src_i;
        if (areset) begin
            m_pend   = '0;
            m_insvc  = '0;
            m_irqs   = '0;
            m_ack    = 1'b0;
            m_hit    = 1'b0;
            m_id     = '0;
            last_rst = cyc;
        end else begin
            s    = samp(cyc - int'(S));
            sd   = samp(cyc - int'(S) - 1);
            rise = s & ~sd;
            for (int t = 0; t < int'(NT); t++) begin
                row       = m_pend & ~m_insvc & irq_en_i[t*N +: N];
                irqs_n[t] = (row != '0);
            end
            tgt   = int'(claim_target_i);
            hit_n = 1'b0;
            id_n  = '0;
            if (claim_i && tgt < int'(NT)) begin
                row = m_pend & ~m_insvc & irq_en_i[tgt*N +: N];
                for (int i = int'(N) - 1; i >= 0; i--) begin
                    if (row[i]) begin
                        hit_n = 1'b1;
                        id_n  = IDW'(i);
                    end
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (EMASK[i]) pend_n[i] = rise[i] | (m_pend[i] & !(hit_n && int'(id_n) == i));
                else          pend_n[i] = s[i];
            end
            svc_n = m_insvc;
            cid   = int'(complete_id_i);
            if (complete_i && cid < int'(N)) svc_n[cid] = 1'b0;
            if (hit_n) svc_n[id_n] = 1'b1;
            m_pend  = pend_n;
            m_insvc = svc_n;
            m_irqs  = irqs_n;
            m_ack   = claim_i;
            m_hit   = hit_n;
            m_id    = id_n;
        end
        cyc++;
        #1;
        chk("model irqs_o",      32'(irqs_o),      32'(m_irqs));
        chk("model claim_ack_o", 32'(claim_ack_o), 32'(m_ack));
        chk("model claim_hit_o", 32'(claim_hit_o), 32'(m_hit));
        chk("model claim_id_o",  32'(claim_id_o),  32'(m_id));
        claim_i    = 1'b0;
        complete_i = 1'b0;
        areset     = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        irq_src_i = '0;
        areset    = 1'b1;
        cycle();
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq_src_i = m;
        cycle();
        irq_src_i = '0;
    endtask

    task automatic claim(input int t);
        claim_i        = 1'b1;
        claim_target_i = TW'(t);
        cycle();
    endtask

    task automatic complete(input int id);
        complete_i    = 1'b1;
        complete_id_i = IDW'(id);
        cycle();
    endtask

    task automatic chk_claim(input string name, input logic hit, input int id);
        chk({name, " ack"}, 32'(claim_ack_o), 32'd1);
        chk({name, " hit"}, 32'(claim_hit_o), 32'(hit));
        chk({name, " id"},  32'(claim_id_o),  32'(id));
    endtask

    initial begin
        int r;
        areset         = 1'b1;
        irq_src_i      = '0;
        irq_en_i       = '0;
        claim_i        = 1'b0;
        claim_target_i = '0;
        complete_i     = 1'b0;
        complete_id_i  = '0;

        // Reset state.
        cycle();
        chk("reset irqs_o", 32'(irqs_o), 32'd0);
        chk("reset ack", 32'(claim_ack_o), 32'd0);

        // Edge latency: ch3, M only.
        irq_en_i = 18'(6'b001000);
        do_reset();
        pulse(6'b001000);
        cycle(); chk("latency +1", 32'(irqs_o), 32'd0);
        cycle(); chk("latency +2", 32'(irqs_o), 32'd0);
        cycle(); chk("latency +3", 32'(irqs_o), 32'b001);

        // Priority claim: ch5 and ch2.
        irq_en_i = 18'(6'b100100);
        do_reset();
        pulse(6'b100100);
        cycles(3);
        chk("prio irqs", 32'(irqs_o), 32'b001);
        claim(0); chk_claim("prio c1", 1'b1, 2); chk("prio c1 irqs", 32'(irqs_o), 32'b001);
        claim(0); chk_claim("prio c2", 1'b1, 5); chk("prio c2 irqs", 32'(irqs_o), 32'b001);
        claim(0); chk_claim("prio c3", 1'b0, 0); chk("prio c3 irqs", 32'(irqs_o), 32'b000);

        // Level channel ch1.
        irq_en_i = 18'(6'b000010);
        do_reset();
        irq_src_i = 6'b000010;
        cycles(4);
        chk("level irqs", 32'(irqs_o), 32'b001);
        claim(0); chk_claim("level c1", 1'b1, 1);
        cycle(); chk("level in svc", 32'(irqs_o), 32'd0);
        complete(1); chk("level cmpl", 32'(irqs_o), 32'd0);
        cycle(); chk("level reassert", 32'(irqs_o), 32'b001);
        claim(0); chk_claim("level c2", 1'b1, 1);
        irq_src_i = '0;
        cycles(3);
        complete(1);
        cycle(); chk("level low +1", 32'(irqs_o), 32'd0);
        cycle(); chk("level low +2", 32'(irqs_o), 32'd0);

        // Re-trigger on ch0.
        irq_en_i = 18'(6'b000001);
        do_reset();
        pulse(6'b000001);
        cycles(3);
        claim(0); chk_claim("retrig c1", 1'b1, 0);
        pulse(6'b000001);
        cycles(4); chk("retrig in svc", 32'(irqs_o), 32'd0);
        complete(0); chk("retrig cmpl", 32'(irqs_o), 32'd0);
        cycle(); chk("retrig reassert", 32'(irqs_o), 32'b001);
        claim(0); chk_claim("retrig c2", 1'b1, 0);

        // Rise on ch4 coinciding with its claim.
        irq_en_i = 18'(6'b010000);
        do_reset();
        pulse(6'b010000);
        cycles(3);
        pulse(6'b010000);
        cycle();
        claim(0); chk_claim("coinc claim", 1'b1, 4);
        complete(4); chk("coinc cmpl", 32'(irqs_o), 32'd0);
        cycle(); chk("coinc still pending", 32'(irqs_o), 32'b001);

        // Completions of an idle ID and of out-of-range IDs.
        irq_en_i = 18'(6'b000100);
        do_reset();
        pulse(6'b000100);
        cycles(3);
        claim(0); chk_claim("idle c1", 1'b1, 2);
        pulse(6'b000100);
        cycles(3);
        complete(7); cycle(); chk("cmpl id7", 32'(irqs_o), 32'd0);
        complete(3); cycle(); chk("cmpl idle id3", 32'(irqs_o), 32'd0);
        complete(6); cycle(); chk("cmpl id6", 32'(irqs_o), 32'd0);
        complete(2); cycle(); chk("cmpl id2", 32'(irqs_o), 32'b001);

        // Multi-target routing and out-of-range target.
        irq_en_i = 18'b000001_000001_000001;
        do_reset();
        pulse(6'b000001);
        cycles(3);
        chk("multi irqs", 32'(irqs_o), 32'b111);
        claim(3); chk_claim("tgt3 miss", 1'b0, 0);
        claim(2); chk_claim("tgt2 hit", 1'b1, 0);
        cycle(); chk("multi removed", 32'(irqs_o), 32'b000);
        claim(0); chk_claim("multi once", 1'b0, 0);

        // Reset mid-operation with a claim in flight.
        irq_en_i = 18'(6'b001101);
        do_reset();
        pulse(6'b001101);
        cycles(3);
        claim(0); chk_claim("midrst c1", 1'b1, 0);
        claim(0); chk_claim("midrst c2", 1'b1, 2);
        areset = 1'b1;
        claim(0);
        chk("midrst irqs", 32'(irqs_o), 32'd0);
        chk("midrst ack",  32'(claim_ack_o), 32'd0);
        chk("midrst hit",  32'(claim_hit_o), 32'd0);
        chk("midrst id",   32'(claim_id_o), 32'd0);
        claim(0); chk_claim("midrst after", 1'b0, 0);

        // Randomised phase.
        irq_src_i = '0;
        for (int k = 0; k < 4000; k++) begin
            if (k % 256 == 0) irq_en_i = 18'($urandom | $urandom);
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, 7) == 0) irq_src_i[i] = ~irq_src_i[i];
            end
            areset         = ($urandom_range(0, 299) == 0);
            claim_i        = ($urandom_range(0, 3) == 0);
            claim_target_i = TW'($urandom_range(0, 3));
            complete_i     = ($urandom_range(0, 3) == 0);
            complete_id_i  = IDW'($urandom_range(0, 7));
            if (m_insvc != '0 && $urandom_range(0, 3) != 0) begin
                r = int'($urandom_range(0, N - 1));
                for (int j = 0; j < int'(N); j++) begin
                    if (m_insvc[(r + j) % N]) begin
                        complete_id_i = IDW'((r + j) % N);
                        break;
                    end
                end
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
